// File: rtl/reg_mux.sv
// rtl/reg_mux.sv - parameterized N-to-1 multiplexer with registered output
module reg_mux #(
    parameter  int WIDTH    = 8,
    parameter  int N_STATES = 4,
    localparam int SEL_W    = (N_STATES > 1) ? $clog2(N_STATES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_x [N_STATES-1:0],
    input  logic [SEL_W-1:0] i_select,
    output logic [WIDTH-1:0] o_x
);

    logic [WIDTH-1:0] o_x_q;
    logic [WIDTH-1:0] o_x_d;

    // Pick the addressed word; an index past the last word yields zero so
    // non-power-of-two sizes never forward an undefined value.
    always_comb begin
        o_x_d = '0;
        for (int k = 0; k < N_STATES; k++) begin
            if (i_select == SEL_W'(k)) begin
                o_x_d = i_x[k];
            end
        end
    end

    // Output register: cleared immediately on reset, otherwise loads the selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_x_q <= '0;
        end else begin
            o_x_q <= o_x_d;
        end
    end

    assign o_x = o_x_q;

endmodule

// File: tb/tb_reg_mux.sv
// tb/tb_reg_mux.sv - scoreboard bench for reg_mux in three sizes
module tb_reg_mux;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    // Default size: 4 words of 8 bits
    logic [7:0] xa [3:0];
    logic [1:0] sela;
    logic [7:0] o_a;

    // Non-power-of-two size: 3 words of 8 bits
    logic [7:0] xb [2:0];
    logic [1:0] selb;
    logic [7:0] o_b;

    // Minimum size: 2 words of 1 bit
    logic [0:0] xc [1:0];
    logic [0:0] selc;
    logic [0:0] o_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         dut;
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    reg_mux #(.WIDTH(8), .N_STATES(4)) u_a (
        .clk(clk), .rst_n(rst_n), .i_x(xa), .i_select(sela), .o_x(o_a)
    );

    reg_mux #(.WIDTH(8), .N_STATES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .i_x(xb), .i_select(selb), .o_x(o_b)
    );

    reg_mux #(.WIDTH(1), .N_STATES(2)) u_c (
        .clk(clk), .rst_n(rst_n), .i_x(xc), .i_select(selc), .o_x(o_c)
    );

    task automatic push(input int dut, input string tag, input logic [7:0] val);
        exp_t e;
        e.dut = dut;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    // Compare every queued expectation against the current outputs.
    task automatic drain();
        exp_t e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       obs = o_a;
                1:       obs = o_b;
                default: obs = {7'b0, o_c};
            endcase
            checks++;
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        xa[0] = 8'h00; xa[1] = 8'hFF; xa[2] = 8'hAA; xa[3] = 8'h23;
        sela  = 2'd3;
        xb[0] = 8'h10; xb[1] = 8'h20; xb[2] = 8'h30;
        selb  = 2'd0;
        xc[0] = 1'b0;  xc[1] = 1'b1;
        selc  = 1'b0;

        // Reset asserted between edges must clear before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        push(0, "rst_async", 8'h00);
        push(1, "rst_async_b", 8'h00);
        push(2, "rst_async_c", 8'h00);
        drain();
        push(0, "rst_hold1", 8'h00);
        tick();
        push(0, "rst_hold2", 8'h00);
        tick();

        // Release and sweep the selects; each result lands one edge later.
        rst_n = 1'b1;
        sela = 2'd0; push(0, "sweep0", 8'h00); tick();
        sela = 2'd1;
        #1;
        push(0, "no_comb_path", 8'h00);
        drain();
        push(0, "sweep1", 8'hFF); tick();
        sela = 2'd2; push(0, "sweep2", 8'hAA); tick();
        sela = 2'd3; push(0, "sweep3", 8'h23); tick();

        // Selected word changes propagate; unselected ones do not.
        sela = 2'd2; push(0, "track_pre", 8'hAA); tick();
        xa[2] = 8'h55; push(0, "track_new", 8'h55); tick();
        xa[1] = 8'h11; push(0, "track_unsel", 8'h55); tick();
        xa[1] = 8'hFF;

        // Asynchronous reset in the middle of a stream.
        sela = 2'd3; push(0, "pre_reset", 8'h23); tick();
        #2 rst_n = 1'b0;
        #1;
        push(0, "mid_reset", 8'h00);
        drain();
        sela = 2'd1;
        rst_n = 1'b1;
        push(0, "post_reset", 8'hFF); tick();

        // Select and newly selected data change in the same cycle.
        sela = 2'd0; xa[0] = 8'h77; push(0, "simul_change", 8'h77); tick();

        // Out-of-range select on the three-word instance.
        selb = 2'd3; push(1, "oor_3", 8'h00); tick();
        selb = 2'd2; push(1, "inr_2", 8'h30); tick();
        selb = 2'd0; push(1, "inr_0", 8'h10); tick();
        selb = 2'd3; push(1, "oor_3_again", 8'h00); tick();

        // Minimal instance: toggling select alternates the output.
        for (int i = 0; i < 6; i++) begin
            selc = 1'(i % 2);
            push(2, $sformatf("toggle%0d", i), 8'(i % 2));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
